press_gen: RTL and testbench

PRESS_GEN -- requirements
Module: press_gen

---
 rtl/press_gen_pkg.sv | 16 +
 rtl/press_gen_if.sv | 16 +
 rtl/press_gen.sv | 194 +++++++++++++++++++
 tb/tb_press_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/press_gen_pkg.sv
// Shared definitions for the press-line generator: FSM state encoding and guard-time formula.
package press_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Guard time in ticks for a given counter width: 2^(width-1) + 2.
  function automatic logic [32:0] guard_ticks(input int unsigned width);
    return (33'd1 << (width - 32'd1)) + 33'd2;
  endfunction

endpackage

// File: rtl/press_gen_if.sv
// Request/status bundle between a press-line controller and press_gen.
interface press_gen_if #(
  parameter int WIDTH = 17
);
  logic             tick_en;
  logic             req;
  logic [WIDTH-1:0] len;
  logic [3:0]       rep;
  logic             out;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (output tick_en, req, len, rep, input out, busy, done, ovf);
  modport slave  (input tick_en, req, len, rep, output out, busy, done, ovf);
endinterface

// File: rtl/press_gen.sv
// Press-line pulse generator with a one-deep pending request slot.
// Optional feature macro PRESS_GEN_REPEAT_EN: each request yields rep+1 presses.
module press_gen
  import press_gen_pkg::*;
#(
  parameter int   WIDTH    = 17,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  press_gen_if.slave  bus
);

  localparam logic [32:0]    GUARD_FULL = guard_ticks(WIDTH);
  localparam logic [WIDTH:0] GUARD      = GUARD_FULL[WIDTH:0];
  localparam logic [WIDTH:0] CNT_ZERO   = {(WIDTH + 1){1'b0}};
  localparam logic [WIDTH:0] CNT_ONE    = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   hold_q, hold_d;
  logic [WIDTH:0]   cnt_inc;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] pend_len_q, pend_len_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
`ifdef PRESS_GEN_REPEAT_EN
  logic [3:0]       rep_cnt_q, rep_cnt_d;
  logic [3:0]       pend_rep_q, pend_rep_d;
`endif

  // Hold length is compared one bit wider than len so the guard clamp never truncates.
  function automatic logic [WIDTH:0] hold_of(input logic [WIDTH-1:0] l);
    logic [WIDTH:0] ext;
    ext = {1'b0, l};
    if (ext > GUARD) begin
      return ext;
    end else begin
      return GUARD;
    end
  endfunction

  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state, counter, pending-slot and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    pend_vld_d = pend_vld_q;
    pend_len_d = pend_len_q;
    ovf_d      = 1'b0;
`ifdef PRESS_GEN_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    pend_rep_d = pend_rep_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A tick in the request cycle is deliberately not counted.
        if (bus.req) begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_ZERO;
          hold_d  = hold_of(bus.len);
`ifdef PRESS_GEN_REPEAT_EN
          rep_cnt_d = bus.rep;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (bus.tick_en) begin
          if (cnt_inc == hold_q) begin
            state_d = ST_GAP;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_GAP: begin
        if (bus.tick_en) begin
          cnt_d = CNT_ZERO;
`ifdef PRESS_GEN_REPEAT_EN
          if (cnt_inc != GUARD) begin
            cnt_d = cnt_inc;
          end else if (rep_cnt_q != 4'd0) begin
            state_d   = ST_ASSERT;
            rep_cnt_d = rep_cnt_q - 4'd1;
          end else begin
            state_d = ST_DONE;
          end
`else
          if (cnt_inc != GUARD) begin
            cnt_d = cnt_inc;
          end else begin
            state_d = ST_DONE;
          end
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        cnt_d = CNT_ZERO;
        if (pend_vld_q) begin
          state_d    = ST_ASSERT;
          hold_d     = hold_of(pend_len_q);
          pend_vld_d = 1'b0;
`ifdef PRESS_GEN_REPEAT_EN
          rep_cnt_d  = pend_rep_q;
`endif
        end else if (bus.req) begin
          // Slot is empty, so the request latched now is consumed at once.
          state_d = ST_ASSERT;
          hold_d  = hold_of(bus.len);
`ifdef PRESS_GEN_REPEAT_EN
          rep_cnt_d = bus.rep;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    if (bus.req && (state_q != ST_IDLE)) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else if (state_q != ST_DONE) begin
        pend_vld_d = 1'b1;
        pend_len_d = bus.len;
`ifdef PRESS_GEN_REPEAT_EN
        pend_rep_d = bus.rep;
`endif
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end else begin
      ovf_d = 1'b0;
    end

    out_d  = (state_d == ST_ASSERT) ? ~IDLE_LVL : IDLE_LVL;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      hold_q     <= CNT_ZERO;
      pend_vld_q <= 1'b0;
      pend_len_q <= {WIDTH{1'b0}};
      out_q      <= IDLE_LVL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef PRESS_GEN_REPEAT_EN
      rep_cnt_q  <= 4'd0;
      pend_rep_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      pend_vld_q <= pend_vld_d;
      pend_len_q <= pend_len_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
`ifdef PRESS_GEN_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      pend_rep_q <= pend_rep_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_press_gen.sv
// Scoreboard bench for press_gen: request-level model predicts press/gap lengths, done and ovf.
module tb_press_gen;

  localparam int   WIDTH    = 4;
  localparam logic IDLE_LVL = 1'b1;
  localparam int   GUARD    = 10;
  localparam int   K_PRESS  = 0;
  localparam int   K_GAP    = 1;
  localparam int   K_DONE   = 2;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  press_gen_if #(.WIDTH(WIDTH)) bus();

  press_gen #(.WIDTH(WIDTH), .IDLE_LVL(IDLE_LVL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   accepted  = 0;
  int   completed = 0;
  int   done_mon  = 0;
  int   exp_ovf   = 0;
  int   seen_ovf  = 0;
  int   tick_mode = 0;
  int   phase     = 0;
  int   cnt       = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic pop_check(input int kind, input int val, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event (value %0d) with empty scoreboard at %0t", name, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d at %0t",
                 name, kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  // Request-level model: at most one active and one pending sequence; anything more is dropped.
  task automatic issue(input int l, input int r);
    int h;
    int presses;
    bus.req = 1'b1;
    bus.len = 4'(l);
    bus.rep = 4'(r);
    if (accepted - completed >= 2) begin
      exp_ovf++;
    end else begin
      accepted++;
      h = (l > GUARD) ? l : GUARD;
`ifdef PRESS_GEN_REPEAT_EN
      presses = r + 1;
`else
      presses = 1;
`endif
      for (int p = 0; p < presses; p++) begin
        exp_q.push_back('{kind: K_PRESS, val: h});
        exp_q.push_back('{kind: K_GAP, val: GUARD});
      end
      exp_q.push_back('{kind: K_DONE, val: 0});
    end
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.len = 4'($urandom);
    bus.rep = 4'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!bus.busy && bus.out == IDLE_LVL && exp_q.size() == 0) break;
    end
    check("wait_idle_in_budget", (k < 5000) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Timebase strobe generator.
  initial begin
    int ph;
    ph = 0;
    bus.tick_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0: begin
          ph = (ph + 1) % 3;
          bus.tick_en = (ph == 0);
        end
        1: bus.tick_en = 1'b1;
        default: bus.tick_en = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Completions free a model slot only after the done cycle has ended.
  always @(posedge clk) completed = done_mon;

  // Monitor: measures press and gap lengths in strobes and matches events against the scoreboard.
  always @(negedge clk) begin
    logic active;
    if (reset) begin
      phase = 0;
      cnt   = 0;
    end else begin
      active = (bus.out != IDLE_LVL);
      if (bus.ovf) begin
        check("ovf_expected", (seen_ovf < exp_ovf) ? 1 : 0, 1);
        seen_ovf++;
      end
      if (phase == 1 && !active) begin
        pop_check(K_PRESS, cnt, "press_len");
        phase = 2;
        cnt   = 0;
      end
      if (phase == 2 && (active || bus.done)) begin
        pop_check(K_GAP, cnt, "gap_len");
        phase = 0;
        cnt   = 0;
      end
      if (bus.done) begin
        pop_check(K_DONE, 0, "done_pulse");
        check("busy_in_done", int'(bus.busy), 1);
        done_mon++;
      end
      if (phase == 0 && active) begin
        phase = 1;
        cnt   = 0;
      end
      if (phase != 0 && bus.tick_en) cnt++;
    end
  end

  initial begin
    int n;
    int k;
    bus.req = 1'b0;
    bus.len = 4'd0;
    bus.rep = 4'd0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out",  int'(bus.out),  int'(IDLE_LVL));
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_ovf",  int'(bus.ovf),  0);
    @(posedge clk);
    #1;

    tick_mode = 0;
    issue(12, 0); wait_idle();
    issue(3, 0);  wait_idle();
    issue(0, 0);  wait_idle();
    issue(15, 0); wait_idle();
    issue(5, 1);  issue(7, 2); issue(9, 0); wait_idle();
    issue(10, 2); wait_idle();

    // Reset partway through a press, with a request held during reset.
    issue(12, 0);
    repeat (16) @(posedge clk);
    #1;
    reset   = 1'b1;
    bus.req = 1'b1;
    exp_q.delete();
    accepted = completed;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    check("midreset_out",  int'(bus.out),  int'(IDLE_LVL));
    check("midreset_busy", int'(bus.busy), 0);
    repeat (40) @(negedge clk);
    check("midreset_stays_idle", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    issue(11, 0); wait_idle();

    // Request landing exactly in the done cycle.
    issue(4, 0);
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_seen_in_budget", (k < 5000) ? 1 : 0, 1);
    issue(6, 1);
    wait_idle();

    tick_mode = 1;
    issue(10, 0); wait_idle();
    issue(13, 1); issue(2, 0); wait_idle();

    for (int it = 0; it < 16; it++) begin
      tick_mode = (it % 2 == 0) ? 2 : 0;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) issue($urandom_range(0, 15), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 60)) @(posedge clk);
        #1;
        issue($urandom_range(0, 15), $urandom_range(0, 2));
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("ovf_count", seen_ovf, exp_ovf);
    check("final_busy", int'(bus.busy), 0);
    check("final_out", int'(bus.out), int'(IDLE_LVL));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
